gdl_subt_packer: RTL and testbench

Builds the 72-bit GDL subtrigger word `SUBT` that the FTD stage consumes. Per-detector input words (CDC, ECL, TOP, KLM) arrive with different pipeline latencies, so each detector has a programmable delay lane that aligns it to a common GDL clock. KEKB and GDL-internal bits are packed alongside, and a fill state machine suppresses output until every lane holds valid history. The block sits between the detector link receivers and the FTD.

---
 rtl/gdl_subt_pkg.sv | 41 ++++
 rtl/gdl_subt_dly_lane.sv | 40 ++++
 rtl/gdl_subt_packer.sv | 114 +++++++++++
 tb/tb_gdl_subt_packer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gdl_subt_pkg.sv
// Shared constants, field layout and FSM encoding for the GDL subtrigger packer.
package gdl_subt_pkg;

    localparam int unsigned SUBT_W     = 72;
    localparam int unsigned DLY_W      = 4;
    localparam int unsigned FCNT_W     = 4;

    localparam int unsigned CDC_LSB    = 0;
    localparam int unsigned CDC_W      = 18;
    localparam int unsigned ECL_LSB    = 18;
    localparam int unsigned ECL_W      = 27;
    localparam int unsigned TOP_LSB    = 45;
    localparam int unsigned TOP_W      = 9;
    localparam int unsigned KLM_LSB    = 54;
    localparam int unsigned KLM_W      = 3;
    localparam int unsigned KEKB_LSB   = 57;
    localparam int unsigned KEKB_W     = 3;
    localparam int unsigned GDLINT_LSB = 60;
    localparam int unsigned GDLINT_W   = 3;
    localparam int unsigned RSVD_LSB   = 63;
    localparam int unsigned RSVD_W     = 8;
    localparam int unsigned PARITY_BIT = 71;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Field order matches the bit layout of SUBT, MSB first.
    typedef struct packed {
        logic                parity;
        logic [RSVD_W-1:0]   rsvd;
        logic [GDLINT_W-1:0] gdlint;
        logic [KEKB_W-1:0]   kekb;
        logic [KLM_W-1:0]    klm;
        logic [TOP_W-1:0]    top;
        logic [ECL_W-1:0]    ecl;
        logic [CDC_W-1:0]    cdc;
    } subt_t;

endpackage

// File: rtl/gdl_subt_dly_lane.sv
// Programmable delay lane: circular buffer with free-running write pointer,
// registered read of (wptr - dly), and a same-edge bypass when dly is zero.
module gdl_subt_dly_lane #(
    parameter int unsigned W     = 18,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid,
    input  logic [W-1:0]               word,
    input  logic [$clog2(DEPTH)-1:0]   dly,
    output logic [W-1:0]               rdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [W-1:0]  wdata_c;
    logic [AW-1:0] raddr_c;

    assign wdata_c = valid ? word : '0;
    assign raddr_c = wptr - dly;

    // Invalid cycles write zero so stale history never leaks into SUBT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rdata <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            mem[wptr] <= wdata_c;
            wptr      <= wptr + AW'(1);
            rdata     <= (dly == '0) ? wdata_c : mem[raddr_c];
        end
    end

endmodule

// File: rtl/gdl_subt_packer.sv
// GDL subtrigger packer: aligns detector lanes, packs SUBT and gates output
// until history is valid. Optional even parity in SUBT[71] via GDL_SUBT_PARITY_EN.
module gdl_subt_packer
    import gdl_subt_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic [CDC_W-1:0]    CDC_WORD,
    input  logic                CDC_VALID,
    input  logic [ECL_W-1:0]    ECL_WORD,
    input  logic                ECL_VALID,
    input  logic [TOP_W-1:0]    TOP_WORD,
    input  logic                TOP_VALID,
    input  logic [KLM_W-1:0]    KLM_WORD,
    input  logic                KLM_VALID,
    input  logic [KEKB_W-1:0]   KEKB,
    input  logic [GDLINT_W-1:0] GDLINT,
    input  logic [DLY_W-1:0]    DLY_CDC,
    input  logic [DLY_W-1:0]    DLY_ECL,
    input  logic [DLY_W-1:0]    DLY_TOP,
    input  logic [DLY_W-1:0]    DLY_KLM,
    output logic [SUBT_W-1:0]   SUBT,
    output logic                SUBT_VALID,
    output logic                FILL_BUSY
);

    logic [CDC_W-1:0]   cdc_rd;
    logic [ECL_W-1:0]   ecl_rd;
    logic [TOP_W-1:0]   top_rd;
    logic [KLM_W-1:0]   klm_rd;
    logic [4*DLY_W-1:0] dly_c;
    logic [4*DLY_W-1:0] dly_shadow;
    logic               dly_chg_c;
    state_t             state;
    state_t             state_n;
    logic [FCNT_W-1:0]  fcnt;
    logic [FCNT_W-1:0]  fcnt_n;
    subt_t              body_c;
    subt_t              out_c;

    gdl_subt_dly_lane #(.W(CDC_W), .DEPTH(DEPTH)) u_cdc (
        .clk(CLK), .rst_n(RESETN), .valid(CDC_VALID), .word(CDC_WORD), .dly(DLY_CDC), .rdata(cdc_rd)
    );
    gdl_subt_dly_lane #(.W(ECL_W), .DEPTH(DEPTH)) u_ecl (
        .clk(CLK), .rst_n(RESETN), .valid(ECL_VALID), .word(ECL_WORD), .dly(DLY_ECL), .rdata(ecl_rd)
    );
    gdl_subt_dly_lane #(.W(TOP_W), .DEPTH(DEPTH)) u_top (
        .clk(CLK), .rst_n(RESETN), .valid(TOP_VALID), .word(TOP_WORD), .dly(DLY_TOP), .rdata(top_rd)
    );
    gdl_subt_dly_lane #(.W(KLM_W), .DEPTH(DEPTH)) u_klm (
        .clk(CLK), .rst_n(RESETN), .valid(KLM_VALID), .word(KLM_WORD), .dly(DLY_KLM), .rdata(klm_rd)
    );

    assign dly_c     = {DLY_CDC, DLY_ECL, DLY_TOP, DLY_KLM};
    assign dly_chg_c = (dly_c != dly_shadow);

    // State, fill counter and delay shadow registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= FILL;
            fcnt       <= '0;
            dly_shadow <= '0;
        end else begin
            state      <= state_n;
            fcnt       <= fcnt_n;
            dly_shadow <= dly_c;
        end
    end

    // Any delay change restarts the fill so every lane re-accumulates history.
    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        if (dly_chg_c) begin
            state_n = FILL;
            fcnt_n  = '0;
        end else if (state == FILL) begin
            fcnt_n = fcnt + FCNT_W'(1);
            if (fcnt == FCNT_W'(15)) begin
                state_n = RUN;
            end
        end
    end

    always_comb begin
        body_c        = '0;
        body_c.cdc    = cdc_rd;
        body_c.ecl    = ecl_rd;
        body_c.top    = top_rd;
        body_c.klm    = klm_rd;
        body_c.kekb   = KEKB;
        body_c.gdlint = GDLINT;
        out_c         = body_c;
`ifdef GDL_SUBT_PARITY_EN
        out_c.parity  = ^body_c;
`endif
    end

    // Outputs follow the next state so RUN is visible on the edge it is entered.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            SUBT       <= '0;
            SUBT_VALID <= 1'b0;
            FILL_BUSY  <= 1'b1;
        end else begin
            SUBT       <= (state_n == RUN) ? SUBT_W'(out_c) : '0;
            SUBT_VALID <= (state_n == RUN);
            FILL_BUSY  <= (state_n == FILL);
        end
    end

endmodule

// File: tb/tb_gdl_subt_packer.sv
// Scoreboard bench for gdl_subt_packer: a cycle-indexed history model predicts
// SUBT/SUBT_VALID/FILL_BUSY for every edge; a monitor compares after each edge.
module tb_gdl_subt_packer;
    import gdl_subt_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [CDC_W-1:0]    cdc_word;
    logic                cdc_valid;
    logic [ECL_W-1:0]    ecl_word;
    logic                ecl_valid;
    logic [TOP_W-1:0]    top_word;
    logic                top_valid;
    logic [KLM_W-1:0]    klm_word;
    logic                klm_valid;
    logic [KEKB_W-1:0]   kekb;
    logic [GDLINT_W-1:0] gdlint;
    logic [DLY_W-1:0]    dly_cdc;
    logic [DLY_W-1:0]    dly_ecl;
    logic [DLY_W-1:0]    dly_top;
    logic [DLY_W-1:0]    dly_klm;
    logic [SUBT_W-1:0]   subt;
    logic                subt_valid;
    logic                fill_busy;

    always #5 clk = ~clk;

    gdl_subt_packer #(.DEPTH(16)) dut (
        .CLK(clk), .RESETN(rst_n),
        .CDC_WORD(cdc_word), .CDC_VALID(cdc_valid),
        .ECL_WORD(ecl_word), .ECL_VALID(ecl_valid),
        .TOP_WORD(top_word), .TOP_VALID(top_valid),
        .KLM_WORD(klm_word), .KLM_VALID(klm_valid),
        .KEKB(kekb), .GDLINT(gdlint),
        .DLY_CDC(dly_cdc), .DLY_ECL(dly_ecl), .DLY_TOP(dly_top), .DLY_KLM(dly_klm),
        .SUBT(subt), .SUBT_VALID(subt_valid), .FILL_BUSY(fill_busy)
    );

    typedef struct {
        logic [SUBT_W-1:0] subt;
        logic              valid;
        logic              busy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // History model: values sampled at edge k are stored at index k (edge 1 is first after reset).
    logic [CDC_W-1:0] h_cdc [0:2047];
    logic [ECL_W-1:0] h_ecl [0:2047];
    logic [TOP_W-1:0] h_top [0:2047];
    logic [KLM_W-1:0] h_klm [0:2047];
    int               n;
    int               last_evt;
    logic [15:0]      dly_prev;

    task automatic check(input string tag, input logic [SUBT_W-1:0] got, input logic [SUBT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n        = 0;
        last_evt = 0;
        dly_prev = '0;
        for (int i = 0; i < 2048; i++) begin
            h_cdc[i] = '0;
            h_ecl[i] = '0;
            h_top[i] = '0;
            h_klm[i] = '0;
        end
    endtask

    // One clock edge: record sampled inputs, predict the outputs, push to scoreboard.
    task automatic tick();
        exp_t              e;
        logic [SUBT_W-1:0] p;
        logic [15:0]       dcur;
        int                i;
        @(posedge clk);
        n++;
        h_cdc[n] = cdc_valid ? cdc_word : '0;
        h_ecl[n] = ecl_valid ? ecl_word : '0;
        h_top[n] = top_valid ? top_word : '0;
        h_klm[n] = klm_valid ? klm_word : '0;
        dcur = {dly_cdc, dly_ecl, dly_top, dly_klm};
        if (dcur != dly_prev) last_evt = n;
        dly_prev = dcur;
        p = '0;
        i = n - int'(dly_cdc) - 1;
        if (i >= 1) p[CDC_LSB +: CDC_W] = h_cdc[i];
        i = n - int'(dly_ecl) - 1;
        if (i >= 1) p[ECL_LSB +: ECL_W] = h_ecl[i];
        i = n - int'(dly_top) - 1;
        if (i >= 1) p[TOP_LSB +: TOP_W] = h_top[i];
        i = n - int'(dly_klm) - 1;
        if (i >= 1) p[KLM_LSB +: KLM_W] = h_klm[i];
        p[KEKB_LSB +: KEKB_W]     = kekb;
        p[GDLINT_LSB +: GDLINT_W] = gdlint;
`ifdef GDL_SUBT_PARITY_EN
        p[PARITY_BIT] = ^p[SUBT_W-2:0];
`endif
        e.valid = ((n - last_evt) >= 16);
        e.busy  = !e.valid;
        e.subt  = e.valid ? p : '0;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic traffic(input int k, input logic [3:0] en);
        for (int j = 0; j < k; j++) begin
            cdc_word  = CDC_W'($urandom);
            ecl_word  = ECL_W'($urandom);
            top_word  = TOP_W'($urandom);
            klm_word  = KLM_W'($urandom);
            cdc_valid = en[0] & 1'($urandom);
            ecl_valid = en[1] & 1'($urandom);
            top_valid = en[2] & 1'($urandom);
            klm_valid = en[3] & 1'($urandom);
            tick();
        end
    endtask

    task automatic quiet(input int k);
        cdc_valid = 1'b0;
        ecl_valid = 1'b0;
        top_valid = 1'b0;
        klm_valid = 1'b0;
        for (int j = 0; j < k; j++) tick();
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("subt", subt, mon_e.subt);
            check("subt_valid", SUBT_W'(subt_valid), SUBT_W'(mon_e.valid));
            check("fill_busy", SUBT_W'(fill_busy), SUBT_W'(mon_e.busy));
        end
    end

    initial begin
        cdc_word = '0; cdc_valid = 1'b0;
        ecl_word = '0; ecl_valid = 1'b0;
        top_word = '0; top_valid = 1'b0;
        klm_word = '0; klm_valid = 1'b0;
        kekb = '0; gdlint = '0;
        dly_cdc = '0; dly_ecl = '0; dly_top = '0; dly_klm = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_subt", subt, '0);
        check("rst_valid", SUBT_W'(subt_valid), '0);
        check("rst_busy", SUBT_W'(fill_busy), SUBT_W'(1));
        rst_n = 1'b1;

        // Fill from reset with all delays zero.
        quiet(20);

        // Single CDC pulse through a 5-cycle lane.
        dly_cdc = 4'd5;
        quiet(18);
        cdc_word = 18'h2A5A5; cdc_valid = 1'b1;
        tick();
        cdc_word = '0;
        quiet(10);

        // ECL at maximum delay (read-address wrap) against TOP bypass.
        dly_ecl = 4'd15; dly_top = 4'd0;
        quiet(18);
        ecl_word = 27'h5A5_A5A5; ecl_valid = 1'b1;
        top_word = 9'h1C3;       top_valid = 1'b1;
        tick();
        quiet(20);

        // KLM delay changes in RUN, second change restarts the fill count.
        dly_klm = 4'd3;
        traffic(20, 4'b1000);
        dly_klm = 4'd4;
        traffic(5, 4'b1000);
        dly_klm = 4'd2;
        traffic(20, 4'b1000);

        // KEKB/GDLINT pass-through alongside random traffic on all lanes.
        kekb = 3'b101; gdlint = 3'b010;
        dly_cdc = 4'd1; dly_ecl = 4'd7; dly_top = 4'd3; dly_klm = 4'd0;
        traffic(40, 4'b1111);

        // Odd-weight CDC word with all other fields zero (parity case).
        kekb = '0; gdlint = '0;
        dly_cdc = 4'd0;
        quiet(18);
        cdc_word = 18'h00007; cdc_valid = 1'b1;
        for (int j = 0; j < 4; j++) tick();
        cdc_valid = 1'b0;
        quiet(3);

        // Asynchronous reset in the middle of RUN with non-zero output.
        kekb = 3'b111; cdc_valid = 1'b1;
        for (int j = 0; j < 3; j++) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_subt", subt, '0);
        check("async_rst_valid", SUBT_W'(subt_valid), '0);
        check("async_rst_busy", SUBT_W'(fill_busy), SUBT_W'(1));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        kekb = 3'b011; gdlint = 3'b100;
        dly_cdc = 4'd2; dly_ecl = 4'd9; dly_top = 4'd15; dly_klm = 4'd6;
        traffic(40, 4'b1111);
        quiet(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
